// File: rtl/b06_pkg.sv
// Shared encodings for the b06 companion datapath: compare-source select,
// status codes and the terminal-counter state type.
package b06_pkg;

    typedef enum logic [1:0] {
        CC_NONE = 2'b00,
        CC_REFA = 2'b01,
        CC_REFB = 2'b10,
        CC_PREV = 2'b11
    } cc_mux_e;

    localparam logic [1:0] US_00 = 2'b00;
    localparam logic [1:0] US_01 = 2'b01;
    localparam logic [1:0] US_11 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/b06_term_counter.sv
// Terminal counter: runs while enable_count is held, stops at TERM and
// flags cont_eql for exactly as long as it sits in DONE.
module b06_term_counter
    import b06_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int TERM  = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_count,
    output logic [CNT_W-1:0] count,
    output logic             cont_eql
);

    localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    cnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + ONE_V;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (enable_count) begin
                    count_d = ONE_V;
                    state_d = (ONE_V == TERM_V) ? DONE : RUN;
                end
            end
            RUN: begin
                if (enable_count) begin
                    count_d = count_inc;
                    if (count_inc == TERM_V) state_d = DONE;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                count_d = TERM_V;
                if (!enable_count) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // cont_eql is registered alongside the state so it tracks DONE exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cont_eql <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cont_eql <= (state_d == DONE);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/b06_cmp_counter.sv
// Companion datapath for the b06 interrupt handler: reference compare,
// terminal counter, status-entry event counter and ack protocol check.
module b06_cmp_counter
    import b06_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int TERM  = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       cc_mux,
    input  logic [1:0]       uscite,
    input  logic             enable_count,
    input  logic             ackout,
    input  logic [CNT_W-1:0] data_in,
    input  logic             ref_we,
    input  logic             ref_sel,
    output logic             eql,
    output logic             cont_eql,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ack_err
);

    logic [CNT_W-1:0] ref_a;
    logic [CNT_W-1:0] ref_b;
    logic [CNT_W-1:0] prev_sample;
    logic [1:0]       prev_uscite;
    logic             eql_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Compare reads the registered references, so a same-edge write is unseen.
    always_comb begin
        eql_d = 1'b0;
        case (cc_mux_e'(cc_mux))
            CC_NONE: eql_d = 1'b0;
            CC_REFA: eql_d = (data_in == ref_a);
            CC_REFB: eql_d = (data_in == ref_b);
            CC_PREV: eql_d = (data_in == prev_sample);
            default: eql_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eql         <= 1'b0;
            ref_a       <= '0;
            ref_b       <= '0;
            prev_sample <= '0;
            prev_uscite <= US_00;
            evt_cnt     <= '0;
            ack_err     <= 1'b0;
        end else begin
            eql         <= eql_d;
            prev_sample <= data_in;
            prev_uscite <= uscite;
            if (ref_we) begin
                if (ref_sel) ref_b <= data_in;
                else         ref_a <= data_in;
            end
            if (uscite == US_11 && prev_uscite != US_11)
                evt_cnt <= sat_inc(evt_cnt);
            if (ackout != enable_count)
                ack_err <= 1'b1;
        end
    end

    b06_term_counter #(
        .CNT_W (CNT_W),
        .TERM  (TERM)
    ) u_term_counter (
        .clock        (clock),
        .reset        (reset),
        .enable_count (enable_count),
        .count        (count),
        .cont_eql     (cont_eql)
    );

endmodule

// File: tb/tb_b06_cmp_counter.sv
// Scoreboard bench for b06_cmp_counter: stimulus pushes expected outputs from
// a run-length/behavioural model; a monitor pops and compares every cycle.
module tb_b06_cmp_counter;

    localparam int CNT_W = 4;
    localparam int TERM  = 9;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       cc_mux = '0;
    logic [1:0]       uscite = '0;
    logic             enable_count = 1'b0;
    logic             ackout = 1'b0;
    logic [CNT_W-1:0] data_in = '0;
    logic             ref_we = 1'b0;
    logic             ref_sel = 1'b0;
    logic             eql;
    logic             cont_eql;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] evt_cnt;
    logic             ack_err;

    b06_cmp_counter #(.CNT_W(CNT_W), .TERM(TERM)) dut (
        .clock        (clock),
        .reset        (reset),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .data_in      (data_in),
        .ref_we       (ref_we),
        .ref_sel      (ref_sel),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .count        (count),
        .evt_cnt      (evt_cnt),
        .ack_err      (ack_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int tag;
        int eql;
        int cont;
        int count;
        int evt;
        int ackerr;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int step_no = 0;

    // Behavioural model state
    int m_ref[2];
    int m_prev = 0;
    int m_prev_us = 0;
    int m_run = 0;
    int m_evt = 0;
    int m_ackerr = 0;

    task automatic check(input string name, input int tag, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, tag, act, expv);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] cc, input logic [1:0] us,
                        input logic en, input logic ack, input logic [3:0] d,
                        input logic we, input logic sel);
        exp_t e;
        @(negedge clock);
        reset = r; cc_mux = cc; uscite = us; enable_count = en; ackout = ack;
        data_in = d; ref_we = we; ref_sel = sel;
        step_no++;
        e.tag = step_no;
        if (r) begin
            m_ref[0] = 0; m_ref[1] = 0; m_prev = 0; m_prev_us = 0;
            m_run = 0; m_evt = 0; m_ackerr = 0;
            e.eql = 0;
        end else begin
            case (int'(cc))
                1: e.eql = (int'(d) == m_ref[0]) ? 1 : 0;
                2: e.eql = (int'(d) == m_ref[1]) ? 1 : 0;
                3: e.eql = (int'(d) == m_prev) ? 1 : 0;
                default: e.eql = 0;
            endcase
            if (we) m_ref[sel] = int'(d);
            m_prev = int'(d);
            // counter = length of the current enable run, clipped at TERM
            m_run = en ? ((m_run < TERM) ? m_run + 1 : TERM) : 0;
            if (us == 2'b11 && m_prev_us != 3 && m_evt < MAXV) m_evt++;
            m_prev_us = int'(us);
            if (ack != en) m_ackerr = 1;
        end
        e.count  = m_run;
        e.cont   = (m_run >= TERM) ? 1 : 0;
        e.evt    = m_evt;
        e.ackerr = m_ackerr;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] us);
        step(1'b0, 2'b00, us, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("eql",      e.tag, 32'(eql),      e.eql);
                check("cont_eql", e.tag, 32'(cont_eql), e.cont);
                check("count",    e.tag, 32'(count),    e.count);
                check("evt_cnt",  e.tag, 32'(evt_cnt),  e.evt);
                check("ack_err",  e.tag, 32'(ack_err),  e.ackerr);
            end
        end
    end

    initial begin : stimulus
        logic en;
        logic [1:0] us;
        // Reset with every input asserted
        repeat (2) step(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1);
        idle(2'b00);

        // Reference compare, including a same-edge write/compare
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1);
        step(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
        step(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);

        // Terminal count, hold in DONE, then release
        repeat (12) step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(2'b00);
        idle(2'b00);

        // Abort before terminal
        repeat (4) step(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(2'b00);
        idle(2'b00);

        // Status-entry events, then saturation
        idle(2'b01); idle(2'b11); idle(2'b11); idle(2'b00); idle(2'b11);
        repeat (20) begin
            idle(2'b11);
            idle(2'b00);
        end

        // Ack protocol error is sticky until reset
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        repeat (3) idle(2'b00);
        repeat (2) step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Closed-loop style random traffic with ackout mirroring enable_count
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: us = 2'b00;
                1: us = 2'b01;
                default: us = 2'b11;
            endcase
            step(1'b0, 2'($urandom_range(0, 3)), us, en, en,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b06_cmp_counter.md
Name: b06_cmp_counter

Overview:
- Companion datapath for the b06 interrupt-handler FSM: consumes its cc_mux, uscite, enable_count and ackout outputs; produces the eql and cont_eql inputs it waits on.
- Holds two reference registers and a comparator selected by cc_mux.
- Runs a terminal counter gated by enable_count and counts uscite=11 events.
- Sits beside b06 in the test harness, closing the loop so both can be simulated as one system.

Parameters:
- CNT_W, 4, width of data_in, references, counter and event counter
- TERM, 9, terminal count value; must be > 0 and < 2**CNT_W

Ports:
- clock  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-high reset
- cc_mux  in  2  compare-source select from b06
- uscite  in  2  status code from b06
- enable_count  in  1  counter run request from b06
- ackout  in  1  acknowledge from b06
- data_in  in  CNT_W  sampled operand; also reference write data
- ref_we  in  1  reference write strobe
- ref_sel  in  1  reference select: 0 = ref_a, 1 = ref_b
- eql  out  1  registered compare result
- cont_eql  out  1  registered terminal-count flag
- count  out  CNT_W  current counter value
- evt_cnt  out  CNT_W  uscite=11 entry count, saturating
- ack_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: eql=0, cont_eql=0, count=0, evt_cnt=0, ack_err=0, ref_a=0, ref_b=0, prev_sample=0, cnt FSM=IDLE, prev_uscite=00. Reset wins over all other inputs on the same edge; mid-run reset aborts to IDLE.
- Reference write: ref_we=1 writes data_in into ref[ref_sel] at the edge. New value is visible to the compare from the next cycle.
- Compare, 1-cycle latency, registered each edge from current inputs:
  - cc_mux=00: eql<=0
  - cc_mux=01: eql<=(data_in==ref_a)
  - cc_mux=10: eql<=(data_in==ref_b)
  - cc_mux=11: eql<=(data_in==prev_sample)
  - prev_sample<=data_in every non-reset cycle.
  - Simultaneous ref_we and compare uses the old ref value.
- Counter FSM states IDLE, RUN, DONE:
  - IDLE: count=0. enable_count=1 -> RUN and count<=1.
  - RUN, enable_count=1: count<=count+1. When count+1==TERM -> DONE and cont_eql<=1 on the same edge.
  - RUN, enable_count=0: abort -> IDLE, count<=0, cont_eql stays 0.
  - DONE, enable_count=1: hold. count=TERM, cont_eql=1.
  - DONE, enable_count=0: -> IDLE, count<=0, cont_eql<=0.
  - No wrap-around: count never exceeds TERM.
  - cont_eql==(state==DONE) at all times.
- Event counter: evt_cnt increments on the edge where uscite==11 and prev_uscite!=11; saturates at 2**CNT_W-1. prev_uscite registers uscite each cycle.
- Ack check: ack_err<=1 when ackout!=enable_count on any non-reset edge. b06 always drives the two equal, so any mismatch is a protocol violation. Cleared only by reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package b06_pkg:
  - cc_mux encodings (CC_NONE=00, CC_REFA=01, CC_REFB=10, CC_PREV=11)
  - uscite codes (US_00, US_01, US_11)
  - counter FSM state typedef (IDLE/RUN/DONE)
- One natural sub-module: b06_term_counter, holding the FSM, count and cont_eql, parameterised by CNT_W/TERM.
- Compare, reference registers and event/ack logic stay in the top.

Test Plan:
- Reset check: reset=1 for 2 cycles with all inputs at 1 -> every output 0 the cycle after release.
- Reference compare: ref_we=1, ref_sel=0, data_in=5; then cc_mux=01, data_in=5 -> eql=1 one cycle later. data_in=6 -> eql=0. cc_mux=00 with data_in=5 -> eql=0.
- Terminal count: enable_count=ackout=1 held for 12 cycles -> count 1..9, then held at 9; cont_eql=1 from the 9th edge on. Drop enable_count and ackout -> next edge count=0, cont_eql=0.
- Abort: enable_count=ackout=1 for 4 cycles, then 0 -> count 4 then 0, cont_eql never 1, FSM in IDLE.
- Events and ack error:
  - uscite sequence 01,11,11,00,11 -> evt_cnt ends at 2.
  - 20 further 11/00 pairs -> evt_cnt saturates at 15.
  - One cycle of ackout=1, enable_count=0 -> ack_err=1, held until reset.
- Closed loop with b06: cont_eql mirrors b06 enable_count gating; no ack_err after 200 random eql/data_in cycles.
